next_pc_predictor: RTL and testbench
====================================

# next_pc_predictor

Generates `PC_next` for the program-counter register each cycle: a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating direction counters, updated from branch/jump resolution in EX. It sits between the EX-stage resolution logic and the PC register's `PC_next` input. The PC register still owns the `hazard` stall; this block only chooses the address.

## Interface
Parameters:
- `IDX_BITS`, 4: BTB index width; the table has 2^IDX_BITS entries.
- `WORD`, `` `WORD_SIZE `` (16): address width.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset; one clock, reset synchronous and active-high
- `PC_cur`  in  WORD  current fetch address from the PC register
- `upd_valid`  in  1  EX resolved a control-flow instruction this cycle
- `upd_pc`  in  WORD  address of the resolved instruction
- `upd_taken`  in  1  actual outcome
- `upd_target`  in  WORD  actual taken target
- `redirect`  in  1  EX detected a misprediction
- `redirect_pc`  in  WORD  correct fetch address
- `PC_next`  out  WORD  address for the PC register to load
- `pred_taken`  out  1  fetch predicted taken; travels down the pipe with the instruction
- `mispred_cnt`  out  16  saturating count of accepted redirects

## Operation
- Index = `PC_cur[IDX_BITS-1:0]`; tag = `PC_cur[WORD-1:IDX_BITS]`. Each entry holds valid, tag, target (WORD) and ctr (2 bits).
- Hit = valid and tag match. Outputs use this priority:
  - `redirect`=1: `PC_next`=`redirect_pc`, `pred_taken`=0.
  - Otherwise, hit and ctr[1]=1: `PC_next`=target, `pred_taken`=1.
  - Otherwise: `PC_next`=`PC_cur`+1 (modulo 2^WORD), `pred_taken`=0.
- Update when `upd_valid`=1, using the index and tag of `upd_pc`:
  - Taken, hit: target ← `upd_target`; ctr increments and saturates at 3.
  - Taken, miss: allocate and overwrite. Valid←1, tag, target, ctr←2.
  - Not taken, hit: ctr decrements and saturates at 0; the entry stays valid.
  - Not taken, miss: no change.
- `mispred_cnt` increments on every cycle with `redirect`=1 and holds at 16'hFFFF.
- `hazard` is not an input. Updates proceed during stalls; EX asserts `upd_valid` exactly once per resolved instruction.

## Timing
- Lookup is combinational: `PC_next` and `pred_taken` are valid in the same cycle as `PC_cur`.
- Table updates take effect at the posedge and are visible to lookups from the next cycle.
- Same-cycle update and lookup of the same index: the lookup sees the pre-update contents. There is no bypass.
- `redirect` together with `upd_valid`: both act. The redirect drives the output and the update writes the table.
- Reset (synchronous, takes priority over updates), on the next posedge:
  - all valid←0
  - all ctr←1
  - `mispred_cnt`←0
- Consequence of reset: `PC_next`=`PC_cur`+1 until the first allocation.
- Reset asserted together with `upd_valid`: the update is dropped.

## Configuration
- `BTB_COUNTER_EN` defined: 2-bit counters as above.
- `BTB_COUNTER_EN` undefined: no counter storage.
  - A hit always predicts taken.
  - Not taken on a hit clears that entry's valid bit.
  - Taken on a hit or miss writes valid, tag and target.
- All other behaviour is identical with or without the macro.

## Structure
- In the shared macro/package file:
  - `` `WORD_SIZE ``
  - `BTB_IDX_BITS` default
  - counter encodings `CTR_SNT`=0, `CTR_WNT`=1, `CTR_WT`=2, `CTR_ST`=3
- One sub-module, `sat_counter2`: combinational next-state for a 2-bit saturating counter (inc/dec). It is instantiated for the update path and excluded when `BTB_COUNTER_EN` is undefined.
- The table is a register array, not a RAM macro, because the read is asynchronous.

## Test plan
- Reset, then `PC_cur`=0x0010 → `PC_next`=0x0011, `pred_taken`=0, `mispred_cnt`=0.
- Update pc=0x0013, taken, target=0x0040; next cycle `PC_cur`=0x0013 → `PC_next`=0x0040, `pred_taken`=1.
- From that state:
  - Two not-taken updates of 0x0013 → ctr 2→1→0; lookup gives `PC_next`=0x0014.
  - Without the macro, one not-taken update already gives 0x0014.
- Aliasing: entry for 0x0013 present; lookup `PC_cur`=0x0023 (same index, different tag) → `PC_next`=0x0024.
  - Then a taken update for 0x0023 → 0x0013 now misses.
- `redirect`=1, `redirect_pc`=0x0100, on a cycle that is also a BTB hit → `PC_next`=0x0100.
  - `mispred_cnt` increments once per redirect cycle; saturation checked from a forced 0xFFFE over 3 redirects → 0xFFFF.
- Same-cycle update and lookup of 0x0013 → the old prediction appears that cycle and the new one the next cycle.
  - Reset together with `upd_valid` → the table stays empty.

Source files
------------

// File: rtl/next_pc_predictor_pkg.sv
// Shared definitions for the next-PC predictor: address width macro,
// default BTB index width, 2-bit counter encodings and update classes.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package next_pc_predictor_pkg;

    localparam int BTB_IDX_BITS = 4;

    // 2-bit direction counter encodings; bit 1 is the taken prediction
    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    // What a resolved control-flow instruction does to its BTB entry
    typedef enum logic [1:0] {
        UPD_NONE      = 2'd0,
        UPD_TAKEN_HIT = 2'd1,
        UPD_ALLOC     = 2'd2,
        UPD_NT_HIT    = 2'd3
    } upd_kind_e;

endpackage

// File: rtl/next_pc_predictor_sat_counter2.sv
// sat_counter2: combinational next state of a 2-bit saturating counter.
// Counts up on inc, down on dec, holds at CTR_ST / CTR_SNT.
module sat_counter2
    import next_pc_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] ctr_next
);

    // Saturating step; inc and dec together cancel out
    always_comb begin
        ctr_next = ctr;
        if (inc && !dec) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else if (dec && !inc) begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// next_pc_predictor: direct-mapped BTB choosing PC_next each cycle.
// Lookup is combinational on PC_cur; updates from EX land at the posedge.
// Optional feature macro BTB_COUNTER_EN: adds per-entry 2-bit direction
// counters. Without it a hit always predicts taken and a not-taken
// resolution on a hit invalidates the entry.
module next_pc_predictor
    import next_pc_predictor_pkg::*;
#(
    parameter int IDX_BITS = BTB_IDX_BITS,
    parameter int WORD     = `WORD_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] PC_cur,
    input  logic            upd_valid,
    input  logic [WORD-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [WORD-1:0] upd_target,
    input  logic            redirect,
    input  logic [WORD-1:0] redirect_pc,
    output logic [WORD-1:0] PC_next,
    output logic            pred_taken,
    output logic [15:0]     mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = WORD - IDX_BITS;

    // Register array: the read port is asynchronous, so no RAM macro
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [WORD-1:0]    target_q [ENTRIES];
`ifdef BTB_COUNTER_EN
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_nxt;
`endif

    logic [15:0]        mispred_q;

    // Lookup side
    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic                lk_hit;
    logic                lk_taken;

    // Update side
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]    up_tag;
    logic                up_hit;
    upd_kind_e           up_kind;

    assign lk_idx = PC_cur[IDX_BITS-1:0];
    assign lk_tag = PC_cur[WORD-1:IDX_BITS];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

`ifdef BTB_COUNTER_EN
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];
`else
    assign lk_taken = lk_hit;
`endif

    assign up_idx = upd_pc[IDX_BITS-1:0];
    assign up_tag = upd_pc[WORD-1:IDX_BITS];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Output select: redirect beats prediction beats sequential fetch
    always_comb begin
        PC_next    = PC_cur + WORD'(1);
        pred_taken = 1'b0;
        if (redirect) begin
            PC_next = redirect_pc;
        end else if (lk_taken) begin
            PC_next    = target_q[lk_idx];
            pred_taken = 1'b1;
        end
    end

    // Classify the resolved instruction against the current table
    always_comb begin
        up_kind = UPD_NONE;
        if (upd_valid) begin
            if (upd_taken) up_kind = up_hit ? UPD_TAKEN_HIT : UPD_ALLOC;
            else if (up_hit) up_kind = UPD_NT_HIT;
        end
    end

`ifdef BTB_COUNTER_EN
    // Counter next state for the entry being updated
    sat_counter2 u_ctr (
        .ctr      (ctr_q[up_idx]),
        .inc      (upd_taken),
        .dec      (!upd_taken),
        .ctr_next (ctr_nxt)
    );
`endif

    // Table write; reset wins over a same-cycle update. Tag and target
    // need no reset because valid gates every use of them.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
`ifdef BTB_COUNTER_EN
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
`endif
        end else begin
            case (up_kind)
                UPD_TAKEN_HIT: begin
                    target_q[up_idx] <= upd_target;
`ifdef BTB_COUNTER_EN
                    ctr_q[up_idx]    <= ctr_nxt;
`endif
                end
                UPD_ALLOC: begin
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= upd_target;
`ifdef BTB_COUNTER_EN
                    ctr_q[up_idx]    <= CTR_WT;
`endif
                end
                UPD_NT_HIT: begin
`ifdef BTB_COUNTER_EN
                    ctr_q[up_idx]    <= ctr_nxt;
`else
                    valid_q[up_idx]  <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    // Saturating count of redirect cycles
    always_ff @(posedge clk) begin
        if (reset) mispred_q <= '0;
        else if (redirect && (mispred_q != 16'hFFFF)) mispred_q <= mispred_q + 16'd1;
    end

    assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed bench for next_pc_predictor; expectations follow the
// BTB_COUNTER_EN setting used for the build.
module tb_next_pc_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] PC_cur;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] PC_next;
    logic        pred_taken;
    logic [15:0] mispred_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    next_pc_predictor dut (
        .clk         (clk),
        .reset       (reset),
        .PC_cur      (PC_cur),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .PC_next     (PC_next),
        .pred_taken  (pred_taken),
        .mispred_cnt (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle update pulse, then drop upd_valid
    task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        step();
        upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [15:0] pc,
                        input logic [15:0] exp_next, input logic exp_pred);
        PC_cur = pc;
        #1;
        chk({tag, "_next"}, 32'(PC_next), 32'(exp_next));
        chk({tag, "_pred"}, 32'(pred_taken), 32'(exp_pred));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; PC_cur = 16'h0; upd_valid = 1'b0; upd_pc = 16'h0;
        upd_taken = 1'b0; upd_target = 16'h0; redirect = 1'b0; redirect_pc = 16'h0;
        step();
        reset = 1'b0;

        // Reset state
        look("rst", 16'h0010, 16'h0011, 1'b0);
        chk("rst_cnt", 32'(mispred_cnt), 32'h0);

        // Allocate and predict
        upd(16'h0013, 1'b1, 16'h0040);
        look("alloc", 16'h0013, 16'h0040, 1'b1);

        // Not-taken walk: ctr 2->1->0 (or invalidate without counters)
        upd(16'h0013, 1'b0, 16'h0);
        look("nt1", 16'h0013, 16'h0014, 1'b0);
        upd(16'h0013, 1'b0, 16'h0);
        look("nt2", 16'h0013, 16'h0014, 1'b0);
        upd(16'h0013, 1'b0, 16'h0);
        look("nt3", 16'h0013, 16'h0014, 1'b0);
        // Taken from floor: counter 0->1 stays not-taken
        upd(16'h0013, 1'b1, 16'h0040);
`ifdef BTB_COUNTER_EN
        look("t_from0", 16'h0013, 16'h0014, 1'b0);
`else
        look("t_from0", 16'h0013, 16'h0040, 1'b1);
`endif
        upd(16'h0013, 1'b1, 16'h0040);
        look("t2", 16'h0013, 16'h0040, 1'b1);
        upd(16'h0013, 1'b1, 16'h0050);
        look("tgt_upd", 16'h0013, 16'h0050, 1'b1);
        upd(16'h0013, 1'b1, 16'h0050);
        // From saturated 3, one not-taken keeps predicting taken
        upd(16'h0013, 1'b0, 16'h0);
`ifdef BTB_COUNTER_EN
        look("sat3_nt", 16'h0013, 16'h0050, 1'b1);
`else
        look("sat3_nt", 16'h0013, 16'h0014, 1'b0);
`endif
        upd(16'h0013, 1'b0, 16'h0);
        look("sat3_nt2", 16'h0013, 16'h0014, 1'b0);
        upd(16'h0013, 1'b1, 16'h0040);
        look("realloc", 16'h0013, 16'h0040, 1'b1);

        // Aliasing on index 3
        look("alias_miss", 16'h0023, 16'h0024, 1'b0);
        upd(16'h0023, 1'b1, 16'h0060);
        look("alias_evict", 16'h0013, 16'h0014, 1'b0);
        look("alias_new", 16'h0023, 16'h0060, 1'b1);

        // Redirect on a hitting cycle
        PC_cur = 16'h0023; redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        chk("redir_next", 32'(PC_next), 32'h0100);
        chk("redir_pred", 32'(pred_taken), 32'h0);
        step();
        redirect = 1'b0;
        chk("redir_cnt1", 32'(mispred_cnt), 32'h1);
        step();
        chk("redir_hold", 32'(mispred_cnt), 32'h1);

        // Redirect and update in the same cycle: both act
        PC_cur = 16'h0013; redirect = 1'b1; redirect_pc = 16'h0200;
        upd_valid = 1'b1; upd_pc = 16'h0013; upd_taken = 1'b1; upd_target = 16'h0070;
        #1;
        chk("redir_upd_next", 32'(PC_next), 32'h0200);
        step();
        redirect = 1'b0; upd_valid = 1'b0;
        chk("redir_upd_cnt", 32'(mispred_cnt), 32'h2);
        look("redir_upd_tbl", 16'h0013, 16'h0070, 1'b1);

        // Counter saturation from 0xFFFE
        force dut.mispred_q = 16'hFFFE;
        #1;
        release dut.mispred_q;
        #1;
        chk("cnt_forced", 32'(mispred_cnt), 32'hFFFE);
        redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cnt_sat", 32'(mispred_cnt), 32'hFFFF);
        end
        redirect = 1'b0;

        // Same-cycle update and lookup: old prediction now, new next cycle
        PC_cur = 16'h0013;
        upd_valid = 1'b1; upd_pc = 16'h0013; upd_taken = 1'b0; upd_target = 16'h0;
        #1;
        chk("same_old", 32'(PC_next), 32'h0070);
        step();
        upd_valid = 1'b0;
        look("same_new", 16'h0013, 16'h0014, 1'b0);

        // Reset with a concurrent update: update is dropped
        reset = 1'b1;
        upd(16'h0033, 1'b1, 16'h0090);
        reset = 1'b0;
        look("rst_upd", 16'h0033, 16'h0034, 1'b0);
        look("rst_clr", 16'h0023, 16'h0024, 1'b0);
        chk("rst_cnt2", 32'(mispred_cnt), 32'h0);
        upd(16'h0023, 1'b1, 16'h0060);
        look("post_rst", 16'h0023, 16'h0060, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
